// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS read/write registers with byte strobes.
// Write and read channels run as independent two-state machines.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); commit when both are held
// W_RESP | write done, presenting bresp until bready
// R_IDLE | arready high, waiting for AR
// R_DATA | presenting rdata/rresp until rready
module axi_lite_slave_regs #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [NUM_REGS*DATA_W-1:0]   regs_q
);

   localparam int STRB_W   = DATA_W / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t              w_state_q, w_state_d;
   r_state_t              r_state_q, r_state_d;
   logic                  aw_got_q, aw_got_d;
   logic                  w_got_q, w_got_d;
   logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_W-1:0]     reg_q [NUM_REGS];
   logic [DATA_W-1:0]     reg_d [NUM_REGS];

   logic                  aw_hs, w_hs, ar_hs;
   logic [ADDR_W-1:0]     addr_eff;
   logic [DATA_W-1:0]     data_eff;
   logic [STRB_W-1:0]     strb_eff;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] idx;
      idx = a >> ADDR_LSB;
      return idx < ADDR_W'(NUM_REGS);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a >> ADDR_LSB);
   endfunction

   // Readies are gated by rst so they drop the instant reset asserts.
   assign awready = rst & (w_state_q == W_IDLE) & ~aw_got_q;
   assign wready  = rst & (w_state_q == W_IDLE) & ~w_got_q;
   assign arready = rst & (r_state_q == R_IDLE);
   assign bvalid  = (w_state_q == W_RESP);
   assign rvalid  = (r_state_q == R_DATA);
   assign bresp   = bresp_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   assign ar_hs = arvalid & arready;

   assign addr_eff = aw_got_q ? awaddr_q : awaddr;
   assign data_eff = w_got_q  ? wdata_q  : wdata;
   assign strb_eff = w_got_q  ? wstrb_q  : wstrb;

   always_comb begin
      w_state_d = w_state_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      reg_d     = reg_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               awaddr_d = awaddr;
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = wdata;
               wstrb_d = wstrb;
            end
            if ((aw_got_q | aw_hs) & (w_got_q | w_hs)) begin
               w_state_d = W_RESP;
               if (addr_in_range(addr_eff)) begin
                  bresp_d = RESP_OKAY;
                  for (int k = 0; k < STRB_W; k++) begin
                     if (strb_eff[k]) reg_d[addr_idx(addr_eff)][k*8 +: 8] = data_eff[k*8 +: 8];
                  end
               end else begin
                  bresp_d = RESP_SLVERR;
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               w_state_d = W_IDLE;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Reads sample reg_q, so a same-edge write commit is not visible yet.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_DATA;
               if (addr_in_range(araddr)) begin
                  rdata_d = reg_q[addr_idx(araddr)];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         R_DATA: begin
            if (rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         reg_q     <= reg_d;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
      assign regs_q[i*DATA_W +: DATA_W] = reg_q[i];
   end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: expected B and R responses are queued
// at issue time from a register model and compared when the DUT responds.
module tb_axi_lite_slave_regs;

   logic          clk, rst;
   logic [31:0]   awaddr, wdata, araddr, rdata;
   logic [3:0]    wstrb;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [1:0]    bresp, rresp;
   logic [255:0]  regs_q;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0]   model [8];
   logic [1:0]    bq [$];
   logic [33:0]   rq [$];

   axi_lite_slave_regs #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8)) dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .regs_q(regs_q)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] idx;
      idx = addr >> 2;
      if (idx < 8) begin
         for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
         bq.push_back(2'b00);
      end else begin
         bq.push_back(2'b10);
      end
   endtask

   task automatic model_read(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr >> 2;
      if (idx < 8) rq.push_back({2'b00, model[idx]});
      else         rq.push_back({2'b10, 32'h0});
   endtask

   task automatic check_regs(input string name);
      logic [255:0] e;
      for (int i = 0; i < 8; i++) e[i*32 +: 32] = model[i];
      n_cmp++;
      if (regs_q !== e) begin
         n_err++;
         $display("FAIL %s regs_q got %h want %h", name, regs_q, e);
      end
   endtask

   task automatic send_aw(input logic [31:0] addr);
      int n = 0;
      awaddr = addr; awvalid = 1;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      n_cmp++;
      if (!awready) begin n_err++; $display("FAIL aw_timeout awready got 0 want 1"); end
      @(negedge clk);
      awvalid = 0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      wdata = data; wstrb = strb; wvalid = 1;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      n_cmp++;
      if (!wready) begin n_err++; $display("FAIL w_timeout wready got 0 want 1"); end
      @(negedge clk);
      wvalid = 0;
   endtask

   task automatic send_ar(input logic [31:0] addr);
      int n = 0;
      araddr = addr; arvalid = 1;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      n_cmp++;
      if (!arready) begin n_err++; $display("FAIL ar_timeout arready got 0 want 1"); end
      @(negedge clk);
      arvalid = 0;
   endtask

   task automatic wait_b();
      int n = 0;
      logic [1:0] e;
      bready = 1;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      n_cmp++;
      if (!bvalid || bq.size() == 0) begin
         n_err++;
         $display("FAIL b_timeout bvalid got %b queued %0d want response", bvalid, bq.size());
         bready = 0;
         return;
      end
      e = bq.pop_front();
      if (bresp !== e) begin n_err++; $display("FAIL bresp got %b want %b", bresp, e); end
      @(negedge clk);
      bready = 0;
      n_cmp++;
      if (bvalid !== 1'b0) begin n_err++; $display("FAIL b_release bvalid got %b want 0", bvalid); end
   endtask

   task automatic wait_r(input int stall);
      int n = 0;
      logic [33:0] e;
      rready = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      n_cmp++;
      if (!rvalid || rq.size() == 0) begin
         n_err++;
         $display("FAIL r_timeout rvalid got %b queued %0d want response", rvalid, rq.size());
         return;
      end
      e = rq.pop_front();
      if ({rresp, rdata} !== e) begin n_err++; $display("FAIL rdata got %b/%h want %b/%h", rresp, rdata, e[33:32], e[31:0]); end
      n_cmp++;
      if (arready !== 1'b0) begin n_err++; $display("FAIL r_arready got %b want 0", arready); end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         n_cmp++;
         if (!rvalid || {rresp, rdata} !== e) begin
            n_err++;
            $display("FAIL r_hold cycle %0d got %b %b/%h want 1 %b/%h", i, rvalid, rresp, rdata, e[33:32], e[31:0]);
         end
      end
      rready = 1;
      @(negedge clk);
      rready = 0;
      n_cmp++;
      if (rvalid !== 1'b0) begin n_err++; $display("FAIL r_release rvalid got %b want 0", rvalid); end
   endtask

   task automatic test_reset();
      rst = 0;
      awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
      araddr = 0; arvalid = 0; rready = 0;
      for (int i = 0; i < 8; i++) model[i] = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || {bresp, rresp, rdata} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_outputs got rdy=%b%b%b v=%b%b resp=%b%b rdata=%h want all 0",
                  awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
      end
      check_regs("reset_regs");
      rst = 1;
      #1;
      n_cmp++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_err++; $display("FAIL reset_release readies got %b%b%b want 111", awready, wready, arready);
      end
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      model_write(32'h4, 32'hDEADBEEF, 4'hF);
      fork
         send_aw(32'h4);
         send_w(32'hDEADBEEF, 4'hF);
      join
      n_cmp++;
      if (bvalid !== 1'b1) begin n_err++; $display("FAIL same_cycle_latency bvalid got %b want 1", bvalid); end
      check_regs("same_cycle_regs");
      wait_b();
      model_read(32'h4);
      send_ar(32'h4);
      wait_r(0);
   endtask

   task automatic test_w_first();
      @(negedge clk);
      model_write(32'h4, 32'h000000AA, 4'h1);
      send_w(32'h000000AA, 4'h1);
      for (int c = 1; c <= 3; c++) begin
         n_cmp++;
         if (wready !== 1'b0 || bvalid !== 1'b0) begin
            n_err++; $display("FAIL w_first_wait N+%0d wready/bvalid got %b/%b want 0/0", c, wready, bvalid);
         end
         if (c < 3) @(negedge clk);
      end
      send_aw(32'h4);
      n_cmp++;
      if (bvalid !== 1'b1) begin n_err++; $display("FAIL w_first_latency bvalid got %b want 1", bvalid); end
      n_cmp++;
      if (regs_q[63:32] !== 32'hDEADBEAA) begin
         n_err++; $display("FAIL w_first_reg1 got %h want deadbeaa", regs_q[63:32]);
      end
      check_regs("w_first_regs");
      wait_b();
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      model_write(32'h20, 32'h99999999, 4'hF);
      fork
         send_aw(32'h20);
         send_w(32'h99999999, 4'hF);
      join
      check_regs("oor_regs");
      wait_b();
      model_read(32'h20);
      send_ar(32'h20);
      wait_r(0);
      model_read(32'hFFFF_FFFC);
      send_ar(32'hFFFF_FFFC);
      wait_r(0);
   endtask

   task automatic test_bready_stall();
      @(negedge clk);
      model_write(32'hC, 32'h11AABB22, 4'h6);
      fork
         send_aw(32'hC);
         send_w(32'h11AABB22, 4'h6);
      join
      bready = 0;
      awaddr = 32'h10; awvalid = 1;
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) begin
            n_err++;
            $display("FAIL b_stall cycle %0d bvalid/bresp/awready/wready got %b/%b/%b/%b want 1/00/0/0",
                     c, bvalid, bresp, awready, wready);
         end
         @(negedge clk);
      end
      check_regs("stall_regs");
      wait_b();
      n_cmp++;
      if (awready !== 1'b1) begin n_err++; $display("FAIL post_b_awready got %b want 1", awready); end
      @(negedge clk);
      awvalid = 0;
      n_cmp++;
      if (awready !== 1'b0) begin n_err++; $display("FAIL post_b_aw_captured awready got %b want 0", awready); end
      model_write(32'h10, 32'h55667788, 4'hF);
      send_w(32'h55667788, 4'hF);
      wait_b();
      check_regs("post_stall_regs");
   endtask

   task automatic test_same_edge();
      @(negedge clk);
      model_read(32'h8);
      model_write(32'h8, 32'h12345678, 4'hF);
      fork
         send_aw(32'h8);
         send_w(32'h12345678, 4'hF);
         send_ar(32'h8);
      join
      fork
         wait_b();
         wait_r(0);
      join
      model_read(32'h8);
      send_ar(32'h8);
      wait_r(0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      model_read(32'h4);
      send_ar(32'h4);
      wait_r(3);
      model_read(32'h7);
      send_ar(32'h7);
      wait_r(0);
      model_read(32'hC);
      send_ar(32'hC);
      wait_r(2);
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      send_aw(32'h4);
      n_cmp++;
      if (awready !== 1'b0) begin n_err++; $display("FAIL abort_aw_held awready got %b want 0", awready); end
      rst = 0;
      #1;
      n_cmp++;
      if ({awready, wready, arready, bvalid} !== 4'b0) begin
         n_err++; $display("FAIL abort_async readies/bvalid got %b%b%b%b want 0000", awready, wready, arready, bvalid);
      end
      for (int i = 0; i < 8; i++) model[i] = 0;
      check_regs("abort_cleared");
      @(negedge clk);
      rst = 1;
      #1;
      n_cmp++;
      if (awready !== 1'b1) begin n_err++; $display("FAIL abort_flag_cleared awready got %b want 1", awready); end
      send_w(32'hCAFEF00D, 4'hF);
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (bvalid !== 1'b0) begin n_err++; $display("FAIL abort_no_b cycle %0d bvalid got %b want 0", c, bvalid); end
         @(negedge clk);
      end
      check_regs("abort_regs");
   endtask

   initial begin
      test_reset();
      test_same_cycle();
      test_w_first();
      test_out_of_range();
      test_bready_stall();
      test_same_edge();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 Parameter ADDR_W, default 32, address width of awaddr/araddr.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be 32 or 64.
REQ-003 Parameter NUM_REGS, default 8, number of RW registers; power of two, 2..256.
REQ-004 clk  in  1  single clock; all state SHALL change on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 awaddr in ADDR_W; awvalid in 1; awready out 1 -- write address channel.
REQ-007 wdata in DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1 -- write data channel.
REQ-008 bresp out 2; bvalid out 1; bready in 1 -- write response channel.
REQ-009 araddr in ADDR_W; arvalid in 1; arready out 1 -- read address channel.
REQ-010 rdata out DATA_W; rresp out 2; rvalid out 1; rready in 1 -- read data channel.
REQ-011 regs_q out NUM_REGS*DATA_W -- current register contents, reg i at bits [i*DATA_W +: DATA_W].

Function
REQ-012 Block SHALL be the responder end of an AXI4-Lite link; a handshake occurs on a cycle where valid and ready are both 1.
REQ-013 Decode: ADDR_LSB = log2(DATA_W/8); index = addr >> ADDR_LSB; in range iff index < NUM_REGS; addr bits below ADDR_LSB SHALL be ignored.
REQ-014 Write FSM states W_IDLE, W_RESP; internal flags aw_got, w_got hold captured awaddr / wdata+wstrb.
REQ-015 In W_IDLE: awready = !aw_got, wready = !w_got; AW and W SHALL be accepted independently, in either order or the same cycle.
REQ-016 On the edge where both AW and W are captured (latched or handshaking that cycle), the write SHALL commit and FSM SHALL go to W_RESP.
REQ-017 Commit in range: byte k of the target register updated iff wstrb[k]=1; bresp=2'b00 (OKAY).
REQ-018 Commit out of range: no register changes; bresp=2'b10 (SLVERR).
REQ-019 In W_RESP: bvalid=1, awready=wready=0, bresp stable; on bready handshake go to W_IDLE and clear both flags.
REQ-020 Write latency: AW and W handshake in cycle N -> regs_q updated after edge N, bvalid=1 in cycle N+1.
REQ-021 Read FSM states R_IDLE, R_DATA; arready = 1 in R_IDLE, 0 in R_DATA.
REQ-022 AR handshake in cycle N: rdata/rresp loaded at edge N, rvalid=1 from cycle N+1; in range -> rresp=2'b00, rdata=register value; out of range -> rresp=2'b10, rdata=0.
REQ-023 In R_DATA rdata/rresp SHALL be held stable until rready handshake, then go to R_IDLE; no back-to-back read without an R_IDLE cycle.
REQ-024 Read and write channels SHALL operate concurrently and independently.
REQ-025 Same-edge read capture and write commit to the same register: rdata SHALL return the pre-write value.
REQ-026 Valid inputs deasserted before handshake SHALL cause no state change; outputs SHALL never depend combinationally on valid/ready inputs.

Reset
REQ-027 rst=0 SHALL immediately force: all registers 0, aw_got=w_got=0, W_IDLE, R_IDLE, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
REQ-028 First cycle after rst rises: awready=wready=arready=1.
REQ-029 Reset mid-transaction SHALL abort it; a partially captured write SHALL NOT commit.

Verification
REQ-030 AW(0x4) and W(0xDEADBEEF, wstrb 0xF) same cycle N -> bvalid in N+1, bresp=00, reg1=0xDEADBEEF; AR 0x4 -> rdata=0xDEADBEEF, rresp=00.
REQ-031 W first (0x000000AA, wstrb 0x1) at N, AW 0x4 at N+3 -> wready=0 during N+1..N+3, reg1=0xDEADBE AA, bvalid in N+4.
REQ-032 Write AW 0x20 (index 8, NUM_REGS=8) -> bresp=10, regs_q unchanged; AR 0x20 -> rdata=0, rresp=10.
REQ-033 bready held 0 for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; new AW accepted only after B handshake.
REQ-034 AR 0x8 captured on the same edge as commit of 0x12345678 to 0x8 (reg2 previously 0) -> rdata=0, subsequent read returns 0x12345678.
REQ-035 After AW-only capture, assert rst=0 for 1 cycle, then send W -> no commit, no bvalid, all regs 0.
